// File: rtl/gg_fpga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gg_fpga : shared types for the trigger window controller             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package gg_fpga;

  typedef enum logic [1:0] {
    STATIC          = 2'd0,
    BOUNCE_BACK     = 2'd1,
    HIT_WIDTH_SHIFT = 2'd2
  } trigger_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    COOL = 2'd2
  } trig_win_state_t;

endpackage
`default_nettype wire

// File: rtl/trigger_window_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trigger_window_gen : phase counter, hit window and bounce/width logic |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module trigger_window_gen
  import gg_fpga::*;
#(
  parameter int PHASE_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               advance,
  input  logic               hit_accept,
  input  logic               hit_reject,
  input  logic               busy,
  input  trigger_mode_t      cfg_mode,
  input  logic [PHASE_W-1:0] cfg_period,
  input  logic [PHASE_W-1:0] cfg_pos,
  input  logic [PHASE_W-1:0] cfg_width,
  input  logic [PHASE_W-1:0] cfg_step,
  output logic [PHASE_W-1:0] win_pos,
  output logic [PHASE_W-1:0] win_width,
  output logic               window_open
);

  typedef logic [PHASE_W:0] ext_t;

  trigger_mode_t      mode_q;
  logic [PHASE_W-1:0] period_q;
  logic [PHASE_W-1:0] step_q;
  logic [PHASE_W-1:0] width_lim_q;
  logic [PHASE_W-1:0] phase_q;
  logic               dir_down_q;

  logic [PHASE_W-1:0] period_in;
  logic [PHASE_W-1:0] pos_in;
  logic [PHASE_W-1:0] room_in;
  logic [PHASE_W-1:0] width_in;

  // Sanitised configuration: period >= 1, window kept inside one period.
  always_comb begin
    period_in = (cfg_period == '0) ? PHASE_W'(1) : cfg_period;
    pos_in    = (cfg_pos > period_in - PHASE_W'(1)) ? period_in - PHASE_W'(1) : cfg_pos;
    room_in   = period_in - pos_in;
    width_in  = (cfg_width > room_in) ? room_in : cfg_width;
  end

  logic wrap;
  assign wrap = advance && (phase_q == period_q - PHASE_W'(1));

  ext_t               upper;
  ext_t               up_sum;
  logic [PHASE_W-1:0] bounce_pos;
  logic               bounce_flip;

  always_comb begin
    upper       = ext_t'(period_q) - ext_t'(win_width);
    up_sum      = ext_t'(win_pos) + ext_t'(step_q);
    bounce_pos  = win_pos;
    bounce_flip = 1'b0;
    if (!dir_down_q) begin
      if (up_sum > upper) begin
        bounce_pos  = upper[PHASE_W-1:0];
        bounce_flip = 1'b1;
      end else begin
        bounce_pos  = up_sum[PHASE_W-1:0];
      end
    end else if (step_q > win_pos) begin
      bounce_pos  = '0;
      bounce_flip = 1'b1;
    end else begin
      bounce_pos  = win_pos - step_q;
    end
  end

  logic [PHASE_W-1:0] room_now;
  logic [PHASE_W-1:0] grow_cap;
  ext_t               grow_sum;
  logic [PHASE_W-1:0] grow_w;
  logic [PHASE_W-1:0] shrink_w;

  always_comb begin
    room_now = period_q - win_pos;
    grow_cap = (width_lim_q < room_now) ? width_lim_q : room_now;
    grow_sum = ext_t'(win_width) + ext_t'(step_q);
    grow_w   = (grow_sum > ext_t'(grow_cap)) ? grow_cap : grow_sum[PHASE_W-1:0];
    shrink_w = (ext_t'(win_width) > ext_t'(step_q) + ext_t'(1)) ? win_width - step_q
                                                                  : PHASE_W'(1);
  end

  ext_t win_end;
  always_comb begin
    win_end     = ext_t'(win_pos) + ext_t'(win_width);
    window_open = busy && (win_width != '0) && (phase_q >= win_pos)
                  && (ext_t'(phase_q) < win_end);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= STATIC;
      period_q    <= PHASE_W'(1);
      step_q      <= '0;
      width_lim_q <= '0;
      phase_q     <= '0;
      dir_down_q  <= 1'b0;
      win_pos     <= '0;
      win_width   <= '0;
    end else if (load) begin
      mode_q      <= cfg_mode;
      period_q    <= period_in;
      step_q      <= cfg_step;
      width_lim_q <= width_in;
      phase_q     <= '0;
      dir_down_q  <= 1'b0;
      win_pos     <= pos_in;
      win_width   <= width_in;
    end else begin
      if (advance) begin
        phase_q <= wrap ? '0 : phase_q + PHASE_W'(1);
      end
      if (wrap && mode_q == BOUNCE_BACK) begin
        win_pos <= bounce_pos;
        if (bounce_flip) begin
          dir_down_q <= ~dir_down_q;
        end
      end
      if (mode_q == HIT_WIDTH_SHIFT) begin
        if (hit_accept) begin
          win_width <= shrink_w;
        end else if (hit_reject) begin
          win_width <= grow_w;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/trigger_window_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trigger_window_ctrl : run FSM, cool-down and hit counters around a    |
// | moving hit window. GG_FPGA_TRIGGER_MISS_CNT_EN adds miss_count.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module trigger_window_ctrl
  import gg_fpga::*;
#(
  parameter int PHASE_W    = 8,
  parameter int CNT_W      = 16,
  parameter int COOL_TICKS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  trigger_mode_t      cfg_mode,
  input  logic [PHASE_W-1:0] cfg_period,
  input  logic [PHASE_W-1:0] cfg_pos,
  input  logic [PHASE_W-1:0] cfg_width,
  input  logic [PHASE_W-1:0] cfg_step,
  input  logic               start,
  input  logic               stop,
  input  logic               tick,
  input  logic               hit_in,
  output logic               busy,
  output logic               window_open,
  output logic [PHASE_W-1:0] win_pos,
  output logic [PHASE_W-1:0] win_width,
  output logic               hit_ok,
  output logic               hit_miss,
`ifdef GG_FPGA_TRIGGER_MISS_CNT_EN
  output logic [CNT_W-1:0]   miss_count,
`endif
  output logic [CNT_W-1:0]   hit_count
);

  localparam int COOL_N = (COOL_TICKS < 1) ? 1 : COOL_TICKS;
  localparam int COOL_W = $clog2(COOL_N + 1);

  trig_win_state_t   state_q;
  trig_win_state_t   state_d;
  logic [COOL_W-1:0] cool_cnt_q;

  logic load;
  logic advance;
  logic hit_eval;
  logic hit_accept;
  logic hit_reject;
  logic cool_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start)      state_d = RUN;
        RUN:     if (hit_accept) state_d = COOL;
        COOL:    if (cool_done)  state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Stop masks every other event in the same cycle.
  always_comb begin
    busy       = (state_q != IDLE);
    load       = (state_q == IDLE) && start && !stop;
    advance    = busy && tick && !stop;
    hit_eval   = (state_q == RUN) && hit_in && !stop;
    hit_accept = hit_eval && window_open;
    hit_reject = hit_eval && !window_open;
    cool_done  = (state_q == COOL) && tick && (cool_cnt_q == COOL_W'(COOL_N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cool_cnt_q <= '0;
      hit_ok     <= 1'b0;
      hit_miss   <= 1'b0;
      hit_count  <= '0;
    end else begin
      hit_ok   <= hit_accept;
      hit_miss <= hit_reject;
      if (state_q != COOL) begin
        cool_cnt_q <= '0;
      end else if (tick) begin
        cool_cnt_q <= cool_cnt_q + COOL_W'(1);
      end
      if (load) begin
        hit_count <= '0;
      end else if (hit_accept && hit_count != '1) begin
        hit_count <= hit_count + CNT_W'(1);
      end
    end
  end

`ifdef GG_FPGA_TRIGGER_MISS_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_count <= '0;
    end else if (load) begin
      miss_count <= '0;
    end else if (hit_miss && miss_count != '1) begin
      miss_count <= miss_count + CNT_W'(1);
    end
  end
`endif

  trigger_window_gen #(
    .PHASE_W (PHASE_W)
  ) u_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .advance     (advance),
    .hit_accept  (hit_accept),
    .hit_reject  (hit_reject),
    .busy        (busy),
    .cfg_mode    (cfg_mode),
    .cfg_period  (cfg_period),
    .cfg_pos     (cfg_pos),
    .cfg_width   (cfg_width),
    .cfg_step    (cfg_step),
    .win_pos     (win_pos),
    .win_width   (win_width),
    .window_open (window_open)
  );

endmodule
`default_nettype wire

// File: tb/tb_trigger_window_ctrl.sv
`default_nettype none
// Directed self-checking bench for trigger_window_ctrl (default parameters).
module tb_trigger_window_ctrl;
  import gg_fpga::*;

  logic          clk = 1'b0;
  logic          rst_n;
  trigger_mode_t cfg_mode;
  logic [7:0]    cfg_period, cfg_pos, cfg_width, cfg_step;
  logic          start, stop, tick, hit_in;
  logic          busy, window_open, hit_ok, hit_miss;
  logic [7:0]    win_pos, win_width;
  logic [15:0]   hit_count;
`ifdef GG_FPGA_TRIGGER_MISS_CNT_EN
  logic [15:0]   miss_count;
`endif

  int passed = 0;
  int total  = 0;

  trigger_window_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_mode    (cfg_mode),
    .cfg_period  (cfg_period),
    .cfg_pos     (cfg_pos),
    .cfg_width   (cfg_width),
    .cfg_step    (cfg_step),
    .start       (start),
    .stop        (stop),
    .tick        (tick),
    .hit_in      (hit_in),
    .busy        (busy),
    .window_open (window_open),
    .win_pos     (win_pos),
    .win_width   (win_width),
    .hit_ok      (hit_ok),
    .hit_miss    (hit_miss),
`ifdef GG_FPGA_TRIGGER_MISS_CNT_EN
    .miss_count  (miss_count),
`endif
    .hit_count   (hit_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic       tick;
    logic       hit;
    logic       exp_open;
    logic [7:0] exp_pos;
    logic       exp_ok;
    logic       exp_miss;
  } vec_t;

  vec_t vecs[22];
  logic [7:0] bounce_exp[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passed++;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    tick = 1'b1;
    repeat (n) cycle();
    tick = 1'b0;
  endtask

  task automatic pulse_hit();
    hit_in = 1'b1;
    cycle();
    hit_in = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
  endtask

  task automatic begin_run(input trigger_mode_t m, input logic [7:0] per, input logic [7:0] pos,
                           input logic [7:0] wid, input logic [7:0] stp);
    cfg_mode = m; cfg_period = per; cfg_pos = pos; cfg_width = wid; cfg_step = stp;
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 0; stop = 0; tick = 0; hit_in = 0;
    cfg_mode = STATIC; cfg_period = 0; cfg_pos = 0; cfg_width = 0; cfg_step = 0;
    repeat (3) cycle();
    chk("rst_busy", busy, 0);
    chk("rst_open", window_open, 0);
    chk("rst_pos", win_pos, 0);
    chk("rst_width", win_width, 0);
    chk("rst_count", hit_count, 0);
    chk("rst_ok_miss", {hit_ok, hit_miss}, 0);
    rst_n = 1'b1;
    cycle();

    // Configuration clamping
    begin_run(STATIC, 8'd0, 8'd5, 8'd3, 8'd0);
    chk("clamp0_busy", busy, 1);
    chk("clamp0_pos", win_pos, 0);
    chk("clamp0_width", win_width, 1);
    chk("clamp0_open", window_open, 1);
    do_stop();
    chk("stop_busy", busy, 0);
    begin_run(STATIC, 8'd10, 8'd12, 8'd5, 8'd0);
    chk("clamp_pos_pos", win_pos, 9);
    chk("clamp_pos_width", win_width, 1);
    do_stop();
    begin_run(STATIC, 8'd10, 8'd8, 8'd5, 8'd0);
    chk("clamp_w_width", win_width, 2);
    do_stop();

    // STATIC: period 10, window [3,5)
    for (int i = 0; i < 20; i++) begin
      int p;
      p = (i + 1) % 10;
      vecs[i] = '{1'b1, 1'b0, (p == 3 || p == 4), 8'd3, 1'b0, 1'b0};
    end
    vecs[20] = '{1'b0, 1'b1, 1'b0, 8'd3, 1'b0, 1'b1};
    vecs[21] = '{1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0};
    begin_run(STATIC, 8'd10, 8'd3, 8'd2, 8'd1);
    chk("static_open0", window_open, 0);
    for (int i = 0; i < 22; i++) begin
      tick = vecs[i].tick;
      hit_in = vecs[i].hit;
      cycle();
      tick = 1'b0;
      hit_in = 1'b0;
      chk($sformatf("static_open[%0d]", i), window_open, vecs[i].exp_open);
      chk($sformatf("static_pos[%0d]", i), win_pos, vecs[i].exp_pos);
      chk($sformatf("static_ok[%0d]", i), hit_ok, vecs[i].exp_ok);
      chk($sformatf("static_miss[%0d]", i), hit_miss, vecs[i].exp_miss);
    end
    cfg_pos = 8'd7;
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("restart_ignored_pos", win_pos, 3);
    chk("restart_ignored_busy", busy, 1);
    stop = 1'b1; start = 1'b1;
    cycle();
    chk("stop_over_start_run", busy, 0);
    cycle();
    stop = 1'b0; start = 1'b0;
    chk("stop_over_start_idle", busy, 0);

    // BOUNCE_BACK
    bounce_exp[0] = 8'd4; bounce_exp[1] = 8'd6; bounce_exp[2] = 8'd2;
    bounce_exp[3] = 8'd0; bounce_exp[4] = 8'd4;
    begin_run(BOUNCE_BACK, 8'd8, 8'd0, 8'd2, 8'd4);
    chk("bounce_pos_init", win_pos, 0);
    for (int i = 0; i < 5; i++) begin
      tick_n(8);
      chk($sformatf("bounce_pos[%0d]", i), win_pos, bounce_exp[i]);
    end
    do_stop();

    // HIT_WIDTH_SHIFT: period 16, window starts at 0
    begin_run(HIT_WIDTH_SHIFT, 8'd16, 8'd0, 8'd5, 8'd2);
    chk("hws_width0", win_width, 5);
    pulse_hit();
    chk("hws_ok1", hit_ok, 1);
    chk("hws_width1", win_width, 3);
    tick_n(16);
    chk("hws_open_wrap", window_open, 1);
    pulse_hit();
    chk("hws_ok2", hit_ok, 1);
    chk("hws_width2", win_width, 1);
    tick_n(16);
    pulse_hit();
    chk("hws_ok3", hit_ok, 1);
    chk("hws_width3", win_width, 1);
    chk("hws_count3", hit_count, 3);
    tick_n(4);
    pulse_hit();
    chk("hws_miss", hit_miss, 1);
    chk("hws_miss_ok", hit_ok, 0);
    chk("hws_width_grow", win_width, 3);
`ifdef GG_FPGA_TRIGGER_MISS_CNT_EN
    cycle();
    chk("hws_miss_count", miss_count, 1);
`endif
    do_stop();

    // COOL window suppresses hits for four ticks
    begin_run(STATIC, 8'd10, 8'd0, 8'd8, 8'd0);
    pulse_hit();
    chk("cool_first_ok", hit_ok, 1);
    tick_n(1);
    pulse_hit();
    chk("cool_ign1", {hit_ok, hit_miss}, 0);
    tick_n(2);
    pulse_hit();
    chk("cool_ign3", {hit_ok, hit_miss}, 0);
    chk("cool_count", hit_count, 1);
    tick_n(1);
    pulse_hit();
    chk("cool_after_ok", hit_ok, 1);
    chk("cool_after_count", hit_count, 2);
    do_stop();

    // Coincident hit + stop
    begin_run(STATIC, 8'd10, 8'd0, 8'd4, 8'd0);
    hit_in = 1'b1; stop = 1'b1;
    cycle();
    hit_in = 1'b0; stop = 1'b0;
    chk("hitstop_pulses", {hit_ok, hit_miss}, 0);
    chk("hitstop_busy", busy, 0);
    chk("hitstop_count", hit_count, 0);

    // Coincident hit + tick at last in-window phase
    begin_run(STATIC, 8'd10, 8'd3, 8'd2, 8'd0);
    tick_n(4);
    chk("edge_open_pre", window_open, 1);
    hit_in = 1'b1; tick = 1'b1;
    cycle();
    hit_in = 1'b0; tick = 1'b0;
    chk("edge_hit_ok", hit_ok, 1);
    chk("edge_open_post", window_open, 0);
    chk("edge_count", hit_count, 1);

    // Asynchronous reset while hit_ok is high
    #1 rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_ok", hit_ok, 0);
    chk("async_pos", win_pos, 0);
    chk("async_width", win_width, 0);
    chk("async_count", hit_count, 0);
    chk("async_open_miss", {window_open, hit_miss}, 0);
    rst_n = 1'b1;
    begin_run(STATIC, 8'd10, 8'd0, 8'd4, 8'd0);
    chk("restart_count", hit_count, 0);
    chk("restart_busy", busy, 1);
    pulse_hit();
    cycle();
    chk("restart_count1", hit_count, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
